// File: rtl/mem2d_clear_arb.sv
// Clear-then-arbitrate controller for a 2-D table in an external single-port synchronous memory.
// After reset the whole array is swept to CLEAR_VAL, then two clients share the port round-robin.
module mem2d_clear_arb #(
   parameter int unsigned     ROWS      = 16,
   parameter int unsigned     COLS      = 16,
   parameter int unsigned     DW        = 8,
   parameter int unsigned     RAW       = 4,
   parameter int unsigned     CAW       = 4,
   parameter logic [DW-1:0]   CLEAR_VAL = 8'h00
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear_start,
   output logic           busy,
   output logic           clear_done,
   input  logic           req0,
   input  logic           we0,
   input  logic [RAW-1:0] row0,
   input  logic [CAW-1:0] col0,
   input  logic [DW-1:0]  wdata0,
   input  logic           req1,
   input  logic           we1,
   input  logic [RAW-1:0] row1,
   input  logic [CAW-1:0] col1,
   input  logic [DW-1:0]  wdata1,
   output logic           gnt0,
   output logic           gnt1,
   output logic           rvalid0,
   output logic           rvalid1,
   output logic [DW-1:0]  rdata,
   output logic           mem_en,
   output logic           mem_we,
   output logic [RAW-1:0] mem_row,
   output logic [CAW-1:0] mem_col,
   output logic [DW-1:0]  mem_wdata,
   input  logic [DW-1:0]  mem_rdata
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_e;

   localparam logic [RAW-1:0] ROW_LAST = RAW'(ROWS - 1);
   localparam logic [CAW-1:0] COL_LAST = CAW'(COLS - 1);

   state_e         state_q, state_d;
   logic [RAW-1:0] row_q, row_d;
   logic [CAW-1:0] col_q, col_d;
   logic           rr_q, rr_d;
   logic           rvalid0_q, rvalid0_d;
   logic           rvalid1_q, rvalid1_d;
   logic           sel0_s, sel1_s;

   // Round-robin pick: rr_q == 0 favours requester 0 when both are asking.
   always_comb begin
      sel0_s = 1'b0;
      sel1_s = 1'b0;
      if (req0 && (!req1 || !rr_q)) begin
         sel0_s = 1'b1;
      end else if (req1) begin
         sel1_s = 1'b1;
      end else begin
         sel0_s = 1'b0;
         sel1_s = 1'b0;
      end
   end

   // Sequencer next-state, sweep counters, grants and memory port drive.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      rr_d       = rr_q;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      busy       = 1'b1;
      clear_done = 1'b0;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_row    = '0;
      mem_col    = '0;
      mem_wdata  = '0;
      case (state_q)
         ST_INIT: begin
            row_d   = '0;
            col_d   = '0;
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_row   = row_q;
            mem_col   = col_q;
            mem_wdata = CLEAR_VAL;
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin
                  row_d      = '0;
                  clear_done = 1'b1;
                  state_d    = ST_READY;
               end else begin
                  row_d = row_q + RAW'(1);
               end
            end else begin
               col_d = col_q + CAW'(1);
            end
         end
         ST_READY: begin
            busy = 1'b0;
            // A clear request pre-empts arbitration; pending requests simply wait.
            if (clear_start) begin
               row_d   = '0;
               col_d   = '0;
               state_d = ST_CLEAR;
            end else if (sel0_s) begin
               gnt0      = 1'b1;
               mem_en    = 1'b1;
               mem_we    = we0;
               mem_row   = row0;
               mem_col   = col0;
               mem_wdata = wdata0;
               rvalid0_d = !we0;
               rr_d      = 1'b1;
            end else if (sel1_s) begin
               gnt1      = 1'b1;
               mem_en    = 1'b1;
               mem_we    = we1;
               mem_row   = row1;
               mem_col   = col1;
               mem_wdata = wdata1;
               rvalid1_d = !we1;
               rr_d      = 1'b0;
            end else begin
               rr_d = rr_q;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State, counters, arbitration pointer and read-return pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         row_q     <= '0;
         col_q     <= '0;
         rr_q      <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         rr_q      <= rr_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   // Shared read bus is forced to zero whenever no return is in flight.
   always_comb begin
      if (rvalid0_q || rvalid1_q) begin
         rdata = mem_rdata;
      end else begin
         rdata = '0;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;

endmodule
